// File: rtl/pattern_player_pkg.sv
// Shared types and constants for the timed-stimulus sequencer.
package pattern_player_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DEF_NUM_CH = 3;
  localparam int unsigned DEF_CH_W   = 32;
  localparam int unsigned DEF_TIME_W = 32;
  localparam int unsigned DEF_DEPTH  = 16;

  // Extract channel i from a packed multi-channel bus of default geometry.
  function automatic logic [DEF_CH_W-1:0] get_ch(
    input logic [DEF_NUM_CH*DEF_CH_W-1:0] bus,
    input int unsigned                    i
  );
    return bus[i*DEF_CH_W +: DEF_CH_W];
  endfunction

endpackage

// File: rtl/pattern_player_mem.sv
// Entry table: synchronous write, combinational read.
module pattern_mem #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned W      = 128
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];

  // Store one entry per accepted write; contents are not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pattern_player.sv
// Timed-stimulus sequencer: loads (time, value) entries while idle and
// replays them at their cycle offsets, optionally looping.
module pattern_player
  import pattern_player_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned CH_W   = DEF_CH_W,
  parameter int unsigned TIME_W = DEF_TIME_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [TIME_W-1:0]         wr_time,
  input  logic [NUM_CH*CH_W-1:0]    wr_data,
  output logic                      wr_ready,
  input  logic                      clear,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      loop_en,
  output logic [NUM_CH*CH_W-1:0]    pat_data,
  output logic                      pat_stb,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               loop_cnt,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      err_order
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CW     = ADDR_W + 1;
  localparam int unsigned DW     = NUM_CH * CH_W;
  localparam int unsigned EW     = TIME_W + DW;

  state_t            state, state_nxt;
  logic [CW-1:0]     count_nxt, rd_ptr, rd_ptr_nxt;
  logic [TIME_W-1:0] last_time, last_time_nxt, timer, timer_nxt;
  logic [DW-1:0]     pat_data_nxt;
  logic              pat_stb_nxt, done_nxt, err_nxt;
  logic [15:0]       loop_cnt_nxt;
  logic              mem_we;
  logic [EW-1:0]     rd_entry;
  logic [TIME_W-1:0] rd_time;
  logic [DW-1:0]     rd_data;

  pattern_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .W      (EW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (count[ADDR_W-1:0]),
    .wdata ({wr_time, wr_data}),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rd_entry)
  );

  assign rd_time  = rd_entry[EW-1 -: TIME_W];
  assign rd_data  = rd_entry[DW-1:0];
  assign busy     = (state == RUN);
  assign wr_ready = (state == IDLE) && !count[ADDR_W];

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      rd_ptr    <= '0;
      last_time <= '0;
      timer     <= '0;
      pat_data  <= '0;
      pat_stb   <= 1'b0;
      done      <= 1'b0;
      err_order <= 1'b0;
      loop_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      rd_ptr    <= rd_ptr_nxt;
      last_time <= last_time_nxt;
      timer     <= timer_nxt;
      pat_data  <= pat_data_nxt;
      pat_stb   <= pat_stb_nxt;
      done      <= done_nxt;
      err_order <= err_nxt;
      loop_cnt  <= loop_cnt_nxt;
    end
  end

  // Next-state: loading/start in IDLE, timed replay in RUN.
  // A loop wrap is taken on the edge that applies the last entry, so the
  // new pass restarts its timer without an extra cycle; a non-looping
  // finish spends one more RUN cycle with rd_ptr==count before done.
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    rd_ptr_nxt    = rd_ptr;
    last_time_nxt = last_time;
    timer_nxt     = timer;
    pat_data_nxt  = pat_data;
    pat_stb_nxt   = 1'b0;
    done_nxt      = 1'b0;
    err_nxt       = err_order;
    loop_cnt_nxt  = loop_cnt;
    mem_we        = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          count_nxt = '0;
          err_nxt   = 1'b0;
        end else if (wr_en && wr_ready) begin
          if (count == '0 || wr_time >= last_time) begin
            mem_we        = 1'b1;
            count_nxt     = count + CW'(1);
            last_time_nxt = wr_time;
          end else begin
            err_nxt = 1'b1;
          end
        end
        if (start) begin
          if (count == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt    = RUN;
            timer_nxt    = '0;
            rd_ptr_nxt   = '0;
            loop_cnt_nxt = '0;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (rd_ptr == count) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          timer_nxt = (timer == '1) ? timer : timer + TIME_W'(1);
          if (rd_time <= timer) begin
            pat_data_nxt = rd_data;
            pat_stb_nxt  = 1'b1;
            if ((rd_ptr + CW'(1)) == count && loop_en) begin
              rd_ptr_nxt   = '0;
              timer_nxt    = '0;
              loop_cnt_nxt = loop_cnt + 16'd1;
            end else begin
              rd_ptr_nxt = rd_ptr + CW'(1);
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pattern_player.sv
// Directed self-checking bench for pattern_player.
module tb_pattern_player;
  import pattern_player_pkg::*;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CH_W   = 32;
  localparam int unsigned TIME_W = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DW     = NUM_CH * CH_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, clear, start, stop, loop_en;
  logic [TIME_W-1:0] wr_time;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [DW-1:0] pat_data;
  logic          pat_stb, busy, done, err_order;
  logic [15:0]   loop_cnt;
  logic [4:0]    count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  pattern_player #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .TIME_W (TIME_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_time   (wr_time),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .clear     (clear),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .pat_data  (pat_data),
    .pat_stb   (pat_stb),
    .busy      (busy),
    .done      (done),
    .loop_cnt  (loop_cnt),
    .count     (count),
    .err_order (err_order)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [31:0] c0, input logic [31:0] c1,
                                       input logic [31:0] c2);
    return {c2, c1, c0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [TIME_W-1:0] t, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_time = t; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  logic [DW-1:0] va, vb, vx;
  logic          exp_stb;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; clear = 1'b0; start = 1'b0; stop = 1'b0;
    loop_en = 1'b0; wr_time = '0; wr_data = '0;
    tick(); tick();
    check("rst_pat_data", pat_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_count", count, 5'd0);
    check("rst_err", err_order, 1'b0);
    rst_n = 1'b1;
    tick();
    check("idle_wr_ready", wr_ready, 1'b1);

    // Test 1: basic replay with equal timestamps
    wr(32'd0, mk(1, 2, 3));
    wr(32'd5, mk(4, 5, 6));
    wr(32'd5, mk(7, 8, 9));
    check("t1_count", count, 5'd3);
    start = 1'b1;
    tick(); // E0
    start = 1'b0;
    check("t1_busy_e0", busy, 1'b1);
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp_stb = (e == 1 || e == 6 || e == 7);
      check($sformatf("t1_stb_e%0d", e), pat_stb, exp_stb);
      if (e == 1) begin
        check("t1_data_e1", pat_data, mk(1, 2, 3));
        check("t1_ch1_e1", get_ch(pat_data, 1), 32'd2);
      end
      if (e == 6) check("t1_data_e6", pat_data, mk(4, 5, 6));
      if (e == 7) check("t1_data_e7", pat_data, mk(7, 8, 9));
      check($sformatf("t1_done_e%0d", e), done, (e == 8) ? 1'b1 : 1'b0);
      if (e == 8) check("t1_busy_e8", busy, 1'b0);
    end
    check("t1_err", err_order, 1'b0);
    check("t1_hold", pat_data, mk(7, 8, 9));

    // Test 2: out-of-order write rejected, clear recovers
    do_clear();
    wr(32'd10, mk(1, 1, 1));
    wr(32'd4, mk(2, 2, 2));
    check("t2_count", count, 5'd1);
    check("t2_err", err_order, 1'b1);
    clear = 1'b1; wr_en = 1'b1; wr_time = 32'd20; // same-cycle write ignored
    tick();
    clear = 1'b0; wr_en = 1'b0;
    check("t2_clr_count", count, 5'd0);
    check("t2_clr_err", err_order, 1'b0);

    // Test 3: fill to DEPTH
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t3_ready_%0d", i), wr_ready, 1'b1);
      wr(TIME_W'(i), mk(i, 0, 0));
    end
    check("t3_ready_full", wr_ready, 1'b0);
    check("t3_count16", count, 5'd16);
    wr(32'd100, mk(9, 9, 9));
    check("t3_count_after17", count, 5'd16);
    check("t3_err_full", err_order, 1'b0);

    // Test 4: looping replay
    do_clear();
    va = mk(32'hA0, 32'hA1, 32'hA2);
    vb = mk(32'hB0, 32'hB1, 32'hB2);
    wr(32'd2, va);
    wr(32'd3, vb);
    loop_en = 1'b1;
    start = 1'b1;
    tick(); // E0
    start = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      exp_stb = (e == 3 || e == 4 || e == 7 || e == 8 || e == 11 || e == 12);
      check($sformatf("t4_stb_e%0d", e), pat_stb, exp_stb);
      if (e == 3 || e == 7 || e == 11) check($sformatf("t4_A_e%0d", e), pat_data, va);
      if (e == 4 || e == 8 || e == 12) check($sformatf("t4_B_e%0d", e), pat_data, vb);
      check($sformatf("t4_lc_e%0d", e), loop_cnt,
            (e < 4) ? 16'd0 : (e < 8) ? 16'd1 : 16'd2);
      check($sformatf("t4_done_e%0d", e), done, (e == 13) ? 1'b1 : 1'b0);
      if (e == 10) loop_en = 1'b0;
    end
    check("t4_busy_end", busy, 1'b0);

    // Test 5: stop mid-run, then reset mid-run
    do_clear();
    vx = mk(32'h11, 32'h22, 32'h33);
    wr(32'd100, vx);
    start = 1'b1;
    tick(); // E0
    start = 1'b0;
    check("t5_lc_cleared", loop_cnt, 16'd0);
    for (int e = 1; e <= 51; e++) begin
      if (e == 51) stop = 1'b1;
      tick();
      stop = 1'b0;
      if (pat_stb !== 1'b0 || done !== 1'b0) check($sformatf("t5_quiet_e%0d", e), {pat_stb, done}, 2'b00);
    end
    check("t5_busy_after_stop", busy, 1'b0);
    check("t5_done_after_stop", done, 1'b0);
    check("t5_hold", pat_data, vb);
    tick();
    check("t5_stb_late", pat_stb, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("t5_busy_rerun", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_data", pat_data, '0);
    check("t5_rst_count", count, 5'd0);
    check("t5_rst_lc", loop_cnt, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Test 6: start with empty table
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_done", done, 1'b1);
    check("t6_busy", busy, 1'b0);
    tick();
    check("t6_done_pulse", done, 1'b0);
    check("t6_busy2", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
